if_fetch_ctrl: RTL
==================

// Module: if_fetch_ctrl
// PURPOSE
//  Sequences instruction fetch for the IF stage: issues one read per PC to the instruction bus,
//  and captures or holds the returned word. Drives the IF stall that freezes the PC register.
//  Discards responses made stale by a pipeline flush. Sits between the PC register, the IF/ID
//  latch and the instruction-side bus master; one fetch outstanding at most.
// PARAMETERS
//  ADDR_W  32  fetch address width
//  DATA_W  32  instruction width
//  CNT_W   32  width of perf counters fetch_cnt / stall_cnt (wrap on overflow)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset; asynchronous, active-low
//  pc_in        in   ADDR_W  current PC (PC register output)
//  hazard_stall in   1       load-use stall from ID; pipeline frozen
//  mem_stall    in   1       data-side bus stall; pipeline frozen
//  flush        in   1       taken jump/branch; PC loads target at this edge
//  rd_req       out  1       read request to instruction bus
//  rd_addr      out  ADDR_W  read address, registered
//  rd_gnt       in   1       request accepted this cycle (rd_req & rd_gnt = handshake)
//  rd_rvalid    in   1       read data valid (single beat)
//  rd_rdata     in   DATA_W  read data
//  if_stall     out  1       to PC register stall input: 1 = hold PC
//  inst_valid   out  1       inst_out holds a fetched word for current pc_in
//  inst_out     out  DATA_W  instruction to IF/ID latch
//  fetch_cnt    out  CNT_W   instructions delivered (advance cycles)
//  stall_cnt    out  CNT_W   cycles with if_stall=1 outside INIT
// BEHAVIOUR
//  Reset (rst=0, async): state=INIT; rd_req=0, rd_addr=0, inst_out=0, hold buffer empty; counters=0.
//  Outputs in reset: if_stall=1, inst_valid=0.
//  Definitions: avail = (WAIT & rd_rvalid) | HOLD. adv = avail & ~hazard_stall & ~mem_stall.
//   if_stall = ~avail (combinational). inst_valid = avail.
//   inst_out = rd_rdata in WAIT, else the held register.
//  States:
//   INIT : exactly one cycle after reset release (PC zeroing cycle), no request -> REQ.
//          rd_addr is loaded from pc_in on this transition.
//   REQ  : rd_req=1 with rd_addr stable until rd_gnt.
//          rd_gnt -> WAIT. flush & rd_gnt -> DROP. flush & ~rd_gnt -> reload rd_addr next cycle, stay REQ.
//   WAIT : rd_rvalid & adv -> REQ; rd_addr<=pc_in's next value, sampled the cycle after adv.
//          rd_rvalid & ~adv -> HOLD, rd_rdata captured.
//          flush & ~rd_rvalid -> DROP.
//   HOLD : word held, if_stall=0. adv -> REQ. flush -> REQ, held word discarded.
//   DROP : rd_req=0, inst_valid=0, if_stall=1. rd_rvalid -> REQ, data discarded; no capture.
//  REQ re-entry: rd_addr is taken from pc_in one cycle after the PC edge (registered address,
//   1 bubble). Minimum fetch latency is therefore 2 cycles REQ->WAIT->data with 0-wait-state bus.
//  Priority: rst > flush > rd_rvalid/adv > hazard/mem stall.
//  A flush in the same cycle as WAIT & rd_rvalid & adv is a normal advance. The PC register loads
//   the target, the returned word is delivered, and downstream kills it via its own flush path.
//  rd_rvalid outside WAIT/DROP is a protocol error: ignored, state unchanged.
//  Never more than one outstanding read. No new rd_req while in WAIT/DROP.
//  fetch_cnt += 1 on adv. stall_cnt += 1 when if_stall & state!=INIT. Both wrap mod 2^CNT_W.
//  Reset asserted mid-fetch: immediate return to INIT. Bus response after reset is ignored by the
//   rvalid rule.
// TESTING
//  1 Reset release, pc_in=0, rd_gnt tied 1, rvalid 1 cycle after gnt:
//    INIT 1 cycle; rd_req@addr 0x0; inst_valid next cycle; fetch_cnt=1.
//  2 Stream with 0-wait bus, pc 0,4,8: each inst delivered every 3rd cycle.
//    if_stall low only on delivery cycles; rd_addr sequence 0x0,0x4,0x8.
//  3 rvalid with hazard_stall=1 for 3 cycles, rdata=0x00A00093:
//    HOLD; inst_out stays 0x00A00093, if_stall=0, no rd_req; adv on release -> REQ.
//  4 flush while WAIT, pc target 0x100, stale rvalid 2 cycles later with rdata=0xDEADBEEF:
//    DROP; inst_valid never 1 for 0xDEADBEEF; next rd_addr=0x100.
//  5 flush while REQ with rd_gnt=0, then target 0x200: rd_addr changes to 0x200 before any
//    handshake; exactly one read issued.
//  6 rst=0 mid-WAIT, then rvalid: all outputs at reset values asynchronously.
//    Late rvalid ignored; fetch_cnt=0; sequence restarts at INIT.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch sequencer with one outstanding instruction read
//   clk, rst (async, active-low)
//   pc_in, hazard_stall, mem_stall, flush : from PC register / pipeline control
//   rd_req, rd_addr, rd_gnt, rd_rvalid, rd_rdata : instruction bus master side
//   if_stall, inst_valid, inst_out : to PC register stall input and IF/ID latch
//   fetch_cnt, stall_cnt : wrapping perf counters
module if_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              hazard_stall,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_rvalid,
  input  logic [DATA_W-1:0] rd_rdata,
  output logic              if_stall,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam logic [2:0] INIT = 3'd0, REQ = 3'd1, WAIT = 3'd2, HOLD = 3'd3, DROP = 3'd4;
  logic [2:0] state, state_nx;
  logic reload, reload_nx, avail, adv, hs, cap;
  logic [DATA_W-1:0] hold_q;
  assign avail = (state == WAIT && rd_rvalid) || state == HOLD;
  assign adv = avail && !hazard_stall && !mem_stall;
  assign if_stall = !avail;
  assign inst_valid = avail;
  assign inst_out = state == WAIT ? rd_rdata : hold_q;
  // a REQ entered after the PC moved spends one bubble cycle with rd_req low while rd_addr picks up pc_in
  assign rd_req = state == REQ && !reload;
  assign hs = rd_req && rd_gnt;
  assign cap = state == WAIT && rd_rvalid && !adv && !flush;
  always_comb begin
    state_nx = state;
    reload_nx = 1'b1;
    case (state)
      INIT: begin
        state_nx = REQ;
        reload_nx = 1'b0;
      end
      REQ: begin
        state_nx = hs ? (flush ? DROP : WAIT) : REQ;
        reload_nx = flush;
      end
      WAIT: state_nx = rd_rvalid ? (cap ? HOLD : REQ) : (flush ? DROP : WAIT);
      HOLD: state_nx = adv || flush ? REQ : HOLD;
      DROP: state_nx = rd_rvalid ? REQ : DROP;
      default: state_nx = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      reload <= 1'b0;
      rd_addr <= '0;
      hold_q <= '0;
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      reload <= reload_nx;
      if (state == INIT || (state == REQ && reload)) rd_addr <= pc_in;
      if (cap) hold_q <= rd_rdata;
      fetch_cnt <= fetch_cnt + CNT_W'(adv);
      stall_cnt <= stall_cnt + CNT_W'(if_stall && state != INIT);
    end
  end
endmodule
